// File: rtl/comparator_serial_chain.sv
// Multi-cycle unsigned magnitude compare, one 2-bit digit per cycle, MSB digit first.
// Latency: DIGITS cycles from acceptance to o_Valid (first mismatch with COMPARATOR_EARLY_EXIT_EN).
// Backpressure: accepts only in IDLE; result held stable in DONE until i_Ready.

// Single-digit comparator: combinational compare of one 2-bit digit pair.
module comparatorTwo (
  input  logic [1:0] i_A,
  input  logic [1:0] i_B,
  output logic       o_GT,
  output logic       o_LT,
  output logic       o_EQ
);
  assign o_GT = (i_A > i_B);
  assign o_LT = (i_A < i_B);
  assign o_EQ = (i_A == i_B);
endmodule

module comparator_serial_chain #(
  parameter int WIDTH = 8
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic                         i_Valid,
  output logic                         o_Ready,
  input  logic [WIDTH-1:0]             i_A,
  input  logic [WIDTH-1:0]             i_B,
  output logic                         o_Valid,
  input  logic                         i_Ready,
  output logic                         o_GT,
  output logic                         o_LT,
  output logic                         o_EQ,
  output logic                         o_Busy,
  output logic [$clog2(WIDTH/2):0]     o_Cycles
);
  localparam int DIGITS = WIDTH / 2;
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW     = $clog2(DIGITS) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   a_sh, b_sh;
  logic [IW-1:0]      idx;
  logic [CW-1:0]      cnt;
  logic               decided, gt_q, lt_q;
  logic               cmp_gt, cmp_lt, cmp_eq;
  logic               last_digit, scan_done;

  // Bring the current digit down to bit 0 so the 2-bit compare sees it.
  assign a_sh = a_q >> {idx, 1'b0};
  assign b_sh = b_q >> {idx, 1'b0};

  comparatorTwo u_digit_cmp (
    .i_A  (a_sh[1:0]),
    .i_B  (b_sh[1:0]),
    .o_GT (cmp_gt),
    .o_LT (cmp_lt),
    .o_EQ (cmp_eq)
  );

  assign last_digit = (idx == '0);
`ifdef COMPARATOR_EARLY_EXIT_EN
  // Stop at the first differing digit; lower digits cannot change the answer.
  assign scan_done  = last_digit || (!decided && !cmp_eq);
`else
  assign scan_done  = last_digit;
`endif

  assign o_Ready  = (state == IDLE);
  assign o_Busy   = (state != IDLE);
  assign o_Cycles = cnt;

  // State register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_Valid && o_Ready) state_nxt = SCAN;
      SCAN:    if (scan_done)          state_nxt = DONE;
      DONE:    if (i_Ready)            state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Operand capture, digit walk, decision tracking and registered result.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      o_Valid <= 1'b0;
      o_GT    <= 1'b0;
      o_LT    <= 1'b0;
      o_EQ    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_Valid) begin
            a_q     <= i_A;
            b_q     <= i_B;
            idx     <= IW'(DIGITS - 1);
            cnt     <= '0;
            decided <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
          end
        end
        SCAN: begin
          cnt <= cnt + CW'(1);
          if (!last_digit) idx <= idx - IW'(1);
          // Only the most significant differing digit decides the result.
          if (!decided && !cmp_eq) begin
            decided <= 1'b1;
            gt_q    <= cmp_gt;
            lt_q    <= cmp_lt;
          end
          if (scan_done) begin
            o_Valid <= 1'b1;
            o_GT    <= decided ? gt_q : cmp_gt;
            o_LT    <= decided ? lt_q : cmp_lt;
            o_EQ    <= !decided && cmp_eq;
          end
        end
        DONE: begin
          // o_Cycles (cnt) deliberately survives the handshake.
          if (i_Ready) begin
            o_Valid <= 1'b0;
            o_GT    <= 1'b0;
            o_LT    <= 1'b0;
            o_EQ    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
